lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver_pkg.sv | 44 ++++
 rtl/lcd_bus_receiver_ddram.sv | 33 +++
 rtl/lcd_bus_receiver.sv | 130 +++++++++++++
 tb/tb_lcd_bus_receiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_receiver_pkg.sv
// Shared constants and address helpers for the HD44780-style bus receiver.
// Covers opcode thresholds, the DDRAM line layout and the cursor stepping rules.
package lcd_bus_receiver_pkg;

    // Instructions decode by highest set bit, so each constant is a threshold.
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_ENTRY    = 8'h04;
    localparam logic [7:0] OP_DISPLAY  = 8'h08;
    localparam logic [7:0] OP_SHIFT    = 8'h10;
    localparam logic [7:0] OP_SET_ADDR = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         LINE_WIDTH = 16;
    localparam int         CELL_COUNT = 32;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    function automatic logic [4:0] cell_index(input logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

    function automatic logic addr_legal(input logic [6:0] addr);
        return addr[5:4] == 2'b00;
    endfunction

    // Moving off either end of a line continues on the other line.
    function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
        if (inc) begin
            if (addr[3:0] == 4'(LINE_WIDTH - 1))
                return addr[6] ? LINE0_BASE : LINE1_BASE;
            return addr + 7'd1;
        end
        if (addr[3:0] == 4'd0)
            return addr[6] ? (LINE0_BASE + 7'(LINE_WIDTH - 1))
                           : (LINE1_BASE + 7'(LINE_WIDTH - 1));
        return addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_ddram.sv
// 32x8 display storage: one synchronous write port, one registered read port.
// Storage contents survive reset; only the read register is cleared.
module lcd_ddram
    import lcd_bus_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [CELL_COUNT];
    logic [7:0] rdata_q;

    // NOTE: the array has no reset so it maps onto plain RAM; clearing it is the
    // clear instruction's job, not the reset's.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // NOTE: non-blocking read samples the pre-write value, so a cell written at
    // one edge appears on rdata_o only after the following edge.
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= 8'h00;
        else     rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receives writes from an HD44780-style parallel bus, keeps a 2x16 character
// image in lcd_ddram and exposes cursor, control flags and busy status.
module lcd_bus_receiver
    import lcd_bus_receiver_pkg::*;
#(
    parameter int         CLR_CYCLES = 32,
    parameter logic [7:0] BLANK      = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       bus_err
);

    localparam int CNT_W = $clog2(CLR_CYCLES + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   clr_cnt_q;
    logic               e_q;
    logic [6:0]         cursor_q;
    logic               disp_on_q, cursor_on_q, blink_on_q, entry_inc_q;
    logic               bus_err_q;
    logic               accept;
    logic               we;
    logic [4:0]         waddr;
    logic [7:0]         wdata;

    assign accept = e_q & ~lcd_e;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = BLANK;
        if (!rst) begin
            if (state_q == CLEAR) begin
                if (clr_cnt_q < CNT_W'(CELL_COUNT)) begin
                    we    = 1'b1;
                    waddr = clr_cnt_q[4:0];
                end
            end else if (accept && lcd_rs && !lcd_rw) begin
                we    = 1'b1;
                waddr = cell_index(cursor_q);
                wdata = lcd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            e_q         <= 1'b0;
            cursor_q    <= LINE0_BASE;
            disp_on_q   <= 1'b0;
            cursor_on_q <= 1'b0;
            blink_on_q  <= 1'b0;
            entry_inc_q <= 1'b1;
            bus_err_q   <= 1'b0;
        end else begin
            e_q       <= lcd_e;
            bus_err_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    // Any strobe landing while the clear runs is dropped.
                    bus_err_q <= accept;
                    clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                    if (clr_cnt_q == CNT_W'(CLR_CYCLES - 1)) state_q <= IDLE;
                end
                default: begin
                    if (accept) begin
                        if (lcd_rw) begin
                            bus_err_q <= 1'b1;
                        end else if (lcd_rs) begin
                            cursor_q <= step_addr(cursor_q, entry_inc_q);
                        end else if (lcd_data >= OP_SET_ADDR) begin
                            if (addr_legal(lcd_data[6:0])) cursor_q  <= lcd_data[6:0];
                            else                           bus_err_q <= 1'b1;
                        end else if (lcd_data >= OP_SHIFT) begin
                            // Shift/function-set/CGRAM: accepted, nothing to model.
                        end else if (lcd_data >= OP_DISPLAY) begin
                            disp_on_q   <= lcd_data[2];
                            cursor_on_q <= lcd_data[1];
                            blink_on_q  <= lcd_data[0];
                        end else if (lcd_data >= OP_ENTRY) begin
                            entry_inc_q <= lcd_data[1];
                        end else if (lcd_data >= OP_HOME) begin
                            cursor_q <= LINE0_BASE;
                        end else if (lcd_data == OP_CLEAR) begin
                            state_q     <= CLEAR;
                            clr_cnt_q   <= '0;
                            cursor_q    <= LINE0_BASE;
                            entry_inc_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_char)
    );

    assign cursor_addr = cursor_q;
    assign disp_on     = disp_on_q;
    assign cursor_on   = cursor_on_q;
    assign blink_on    = blink_on_q;
    assign entry_inc   = entry_inc_q;
    assign busy        = (state_q == CLEAR);
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed scenarios with literal
// expectations, then randomized bus traffic against a transaction-level model.
module tb_lcd_bus_receiver;

    localparam int         CLR   = 32;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       disp_on, cursor_on, blink_on, entry_inc, busy, bus_err;

    lcd_bus_receiver #(.CLR_CYCLES(CLR), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_inc(entry_inc), .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [32];
    bit         m_known [32];
    bit         m_valid = 0;
    bit         m_e_d, m_fall;
    logic [6:0] m_cursor;
    bit         m_disp, m_curs, m_blink, m_inc, m_err;
    int         m_busy_left;
    logic [7:0] m_rd;
    bit         m_rd_known;

    initial for (int i = 0; i < 32; i++) m_known[i] = 0;

    // Cursor treated as a linear position 0..31 around both lines.
    function automatic int pos_of(input logic [6:0] a);
        return (a[6] ? 16 : 0) + int'(a[3:0]);
    endfunction

    function automatic logic [6:0] addr_of(input int p);
        return (p >= 16) ? 7'(64 + p - 16) : 7'(p);
    endfunction

    task automatic m_write(input int idx, input logic [7:0] d);
        m_mem[idx]   = d;
        m_known[idx] = 1;
    endtask

    task automatic m_txn(input bit rs, input bit rw, input logic [7:0] d);
        int a;
        if (rw) m_err = 1;
        else if (rs) begin
            m_write(pos_of(m_cursor), d);
            m_cursor = addr_of(m_inc ? (pos_of(m_cursor) + 1) % 32 : (pos_of(m_cursor) + 31) % 32);
        end else if (d >= 8'h80) begin
            a = int'(d[6:0]);
            if (a <= 'h0F || (a >= 'h40 && a <= 'h4F)) m_cursor = d[6:0];
            else m_err = 1;
        end else if (d >= 8'h10) begin
            m_err = 0;
        end else if (d >= 8'h08) begin
            m_disp = d[2]; m_curs = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
            m_inc = d[1];
        end else if (d >= 8'h02) begin
            m_cursor = 7'h00;
        end else if (d == 8'h01) begin
            m_busy_left = CLR;
            m_cursor    = 7'h00;
            m_inc       = 1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_e_d = 0; m_cursor = 7'h00;
            m_disp = 0; m_curs = 0; m_blink = 0; m_inc = 1;
            m_busy_left = 0; m_err = 0; m_rd = 8'h00; m_rd_known = 1;
        end else begin
            m_fall     = m_e_d && !lcd_e;
            m_e_d      = lcd_e;
            m_rd       = m_mem[rd_addr];
            m_rd_known = m_known[rd_addr];
            m_err      = 0;
            if (m_busy_left > 0) begin
                // Clear blanks cell k on the (k+1)-th cycle after acceptance.
                if (CLR - m_busy_left < 32) m_write(CLR - m_busy_left, BLANK);
                m_busy_left--;
                if (m_fall) m_err = 1;
            end else if (m_fall) begin
                m_txn(lcd_rs, lcd_rw, lcd_data);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int err_pulses = 0;
    int busy_run = 0;
    int last_busy_len = 0;

    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            if (m_rd_known) check("rd_char", rd_char, m_rd);
            check("cursor_addr", cursor_addr, m_cursor);
            check("flags", {disp_on, cursor_on, blink_on, entry_inc}, {m_disp, m_curs, m_blink, m_inc});
            check("busy", busy, m_busy_left > 0);
            check("bus_err", bus_err, m_err);
            err_pulses += int'(bus_err);
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_rd = 0;

    task automatic tick();
        @(negedge clk);
        if (rand_rd) rd_addr = 5'($urandom_range(0, 31));
    endtask

    task automatic bus_write(input bit rs, input bit rw, input logic [7:0] d,
                             input int hi_len, input int lo_len);
        tick();
        lcd_e = 1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        repeat (hi_len - 1) tick();
        tick();
        lcd_e = 0;
        repeat (lo_len) tick();
    endtask

    task automatic instr(input logic [7:0] d);
        bus_write(0, 0, d, 1, 1);
    endtask

    task automatic data(input logic [7:0] d);
        bus_write(1, 0, d, 1, 1);
    endtask

    task automatic read_cell(input int k, output logic [7:0] v);
        @(negedge clk);
        rd_addr = 5'(k);
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("busy_done", busy, 0);
    endtask

    logic [7:0] v;
    int e0;

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_flags", {disp_on, cursor_on, blink_on, entry_inc}, 4'b0001);
        check("rst_busy_err", {busy, bus_err}, 2'b00);
        check("rst_rd_char", rd_char, 8'h00);

        // Function set, display on, entry increment.
        e0 = err_pulses;
        instr(8'h38); instr(8'h0C); instr(8'h06);
        check("init_flags", {disp_on, cursor_on, blink_on, entry_inc}, 4'b1001);
        check("init_no_err", err_pulses - e0, 0);

        data(8'h35); data(8'h2B); data(8'h37);
        read_cell(0, v); check("cell0", v, 8'h35);
        read_cell(1, v); check("cell1", v, 8'h2B);
        read_cell(2, v); check("cell2", v, 8'h37);
        check("cursor_03", cursor_addr, 7'h03);
        check("model_cursor_03", m_cursor, 7'h03);

        instr(8'h8F); data(8'h41); data(8'h42);
        read_cell(15, v); check("cell15", v, 8'h41);
        read_cell(16, v); check("cell16", v, 8'h42);
        check("cursor_41", cursor_addr, 7'h41);

        // Clear, with a data write attempted while it is running.
        e0 = err_pulses;
        instr(8'h01);
        data(8'h55);
        wait_not_busy();
        check("busy_len", last_busy_len, 32);
        check("err_during_busy", err_pulses - e0, 1);
        check("cursor_after_clear", cursor_addr, 7'h00);
        for (int k = 0; k < 32; k++) begin
            read_cell(k, v);
            check("blank_cell", v, 8'h20);
        end
        check("model_cell31", m_mem[31], 8'h20);

        e0 = err_pulses;
        instr(8'hA0);
        check("err_bad_addr", err_pulses - e0, 1);
        check("cursor_kept", cursor_addr, 7'h00);
        e0 = err_pulses;
        bus_write(0, 1, 8'h00, 1, 1);
        check("err_read", err_pulses - e0, 1);

        instr(8'h04); instr(8'h80); data(8'h31);
        read_cell(0, v); check("cell0_dec", v, 8'h31);
        check("cursor_4f", cursor_addr, 7'h4F);

        // Reset abandons a running clear and leaves unvisited cells alone.
        instr(8'hC4); data(8'h77);
        instr(8'h01);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        rst = 0;
        read_cell(20, v); check("cell20_kept", v, 8'h77);

        // Falling strobe coinciding with reset is discarded.
        @(negedge clk); lcd_e = 1; lcd_rs = 0; lcd_rw = 0; lcd_data = 8'h0F;
        @(negedge clk); lcd_e = 0; rst = 1;
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        check("disp_after_discard", disp_on, 0);

        // Randomized traffic; the per-cycle compare does the checking.
        rand_rd = 1;
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [7:0] d;
            op = $urandom_range(0, 99);
            if (op < 40) begin
                bus_write(1, 0, 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
            end else if (op < 48) begin
                bus_write($urandom_range(0, 1) == 1, 1, 8'($urandom), 1, 1);
            end else if (op < 60) begin
                if ($urandom_range(0, 1) == 1) d = {1'b1, 1'($urandom), 2'b00, 4'($urandom)};
                else d = 8'h80 | 8'($urandom);
                instr(d);
            end else if (op < 68) begin
                instr(8'h04 | 8'($urandom_range(0, 3)));
            end else if (op < 76) begin
                instr(8'h08 | 8'($urandom_range(0, 7)));
            end else if (op < 81) begin
                instr(8'h02 | 8'($urandom_range(0, 1)));
            end else if (op < 85) begin
                instr(8'h01);
                if ($urandom_range(0, 1) == 1) wait_not_busy();
            end else if (op < 88) begin
                tick(); rst = 1;
                tick(); rst = 0;
            end else begin
                instr(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range('h10, 'h7F)));
            end
        end
        rand_rd = 0;
        wait_not_busy();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
